// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, constants and mode encoding for the bf16 weight-stationary PE
package pe_pkg;
    localparam int BF16_W = 16;
    localparam int FP32_W = 32;
    localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;
    typedef enum logic {PE_MODE_FMA = 1'b0, PE_MODE_BYPASS = 1'b1} pe_mode_e;
endpackage

// File: rtl/pe_bf16_ws_if.sv
// pe_bf16_ws_if: all data, valid and control signals of one PE; clk/reset stay outside
interface pe_bf16_ws_if
    import pe_pkg::*;
#(
    parameter int IN_W  = BF16_W,
    parameter int ACC_W = FP32_W,
    parameter int CNT_W = 32
);
    logic             i_en;
    logic             i_mode;
    logic             i_wload;
    logic             i_wswap;
    logic [IN_W-1:0]  i_weight;
    logic [IN_W-1:0]  o_weight;
    logic [IN_W-1:0]  i_west;
    logic             i_west_valid;
    logic [IN_W-1:0]  o_east;
    logic             o_east_valid;
    logic [ACC_W-1:0] i_north;
    logic             i_north_valid;
    logic [ACC_W-1:0] o_south;
    logic             o_south_valid;
    logic             o_busy;
    logic [CNT_W-1:0] o_mac_count;

    modport master (
        output i_en, i_mode, i_wload, i_wswap, i_weight, i_west, i_west_valid, i_north, i_north_valid,
        input  o_weight, o_east, o_east_valid, o_south, o_south_valid, o_busy, o_mac_count
    );
    modport slave (
        input  i_en, i_mode, i_wload, i_wswap, i_weight, i_west, i_west_valid, i_north, i_north_valid,
        output o_weight, o_east, o_east_valid, o_south, o_south_valid, o_busy, o_mac_count
    );
endinterface

// File: rtl/pe_bf16_fma.sv
// pe_bf16_fma: combinational bf16 x bf16 + fp32 -> fp32, round-to-nearest-even, subnormals flushed to zero
module pe_bf16_fma
    import pe_pkg::*;
(
    input  logic [BF16_W-1:0] a_i,
    input  logic [BF16_W-1:0] b_i,
    input  logic [FP32_W-1:0] c_i,
    output logic [FP32_W-1:0] r_o
);
    logic a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, a_zero, b_zero, c_zero;
    logic p_nan, p_inf, p_zero, p_big, sp, sl, ss, up;
    logic [15:0] prod;
    logic [23:0] mp, mc, ml, ms;
    logic signed [10:0] ep, ec, el, es, d, er;
    logic [26:0] al, ax, sh, n;
    logic [27:0] sum;
    logic [4:0] lz;
    logic [30:0] rb;

    // the 8x8-bit product is exact in fp32, so only the final add rounds
    always_comb begin
        a_nan  = &a_i[14:7] && |a_i[6:0];
        b_nan  = &b_i[14:7] && |b_i[6:0];
        c_nan  = &c_i[30:23] && |c_i[22:0];
        a_inf  = &a_i[14:7] && !(|a_i[6:0]);
        b_inf  = &b_i[14:7] && !(|b_i[6:0]);
        c_inf  = &c_i[30:23] && !(|c_i[22:0]);
        a_zero = a_i[14:7] == '0;
        b_zero = b_i[14:7] == '0;
        c_zero = c_i[30:23] == '0;
        sp     = a_i[15] ^ b_i[15];
        prod   = 16'({1'b1, a_i[6:0]}) * 16'({1'b1, b_i[6:0]});
        ep     = $signed({3'b0, a_i[14:7]}) + $signed({3'b0, b_i[14:7]}) - 11'sd127 + $signed({10'b0, prod[15]});
        mp     = prod[15] ? {prod, 8'b0} : {prod[14:0], 9'b0};
        ec     = $signed({3'b0, c_i[30:23]});
        mc     = {1'b1, c_i[22:0]};
        p_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
        p_zero = a_zero || b_zero || (ep <= 11'sd0);
        p_inf  = !p_nan && (a_inf || b_inf || (!p_zero && ep >= 11'sd255));
        p_big  = (ep > ec) || (ep == ec && mp >= mc);
        sl     = p_big ? sp : c_i[31];
        ss     = p_big ? c_i[31] : sp;
        el     = p_big ? ep : ec;
        es     = p_big ? ec : ep;
        ml     = p_big ? mp : mc;
        ms     = p_big ? mc : mp;
        d      = el - es;
        al     = {ml, 3'b0};
        sh     = {ms, 3'b0} >> d[4:0];
        ax     = (d >= 11'sd27) ? 27'd1 : {sh[26:1], sh[0] | (|({ms, 3'b0} & ~(27'h7FF_FFFF << d[4:0])))};
        sum    = (sl == ss) ? {1'b0, al} + {1'b0, ax} : {1'b0, al} - {1'b0, ax};
        lz     = '0;
        for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
        n      = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0] << lz;
        er     = sum[27] ? el + 11'sd1 : el - $signed({6'b0, lz});
        up     = n[2] && (n[1] || n[0] || n[3]);
        rb     = {er[7:0], n[25:3]} + {30'b0, up};
        if (p_nan || c_nan || (p_inf && c_inf && sp != c_i[31])) r_o = FP32_QNAN;
        else if (p_inf || c_inf) r_o = {p_inf ? sp : c_i[31], 8'hFF, 23'b0};
        else if (p_zero && c_zero) r_o = {sp & c_i[31], 31'b0};
        else if (p_zero) r_o = c_i;
        else if (c_zero) r_o = {sp, ep[7:0], mp[22:0]};
        else if (!n[26]) r_o = FP32_ZERO;
        else if (er >= 11'sd255) r_o = {sl, 8'hFF, 23'b0};
        else if (er <= 11'sd0) r_o = {sl, 31'b0};
        else r_o = {sl, rb};
    end
endmodule

// File: rtl/pe_delay_line.sv
// pe_delay_line: enable-gated shift register with every stage exposed and sync active-low clear
module pe_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en_i,
    input  logic [WIDTH-1:0]            d_i,
    output logic [DEPTH-1:0][WIDTH-1:0] taps_o,
    output logic [WIDTH-1:0]            q_o
);
    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // shift one stage per enabled cycle; clear drops everything in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
        end
    end

    assign taps_o = stage_q;
    assign q_o    = stage_q[DEPTH-1];
endmodule

// File: rtl/pe_bf16_ws.sv
// pe_bf16_ws: weight-stationary bf16 PE with double-buffered weights, valid pipeline, bypass and MAC counter
module pe_bf16_ws
    import pe_pkg::*;
#(
    parameter int IN_W    = BF16_W,
    parameter int ACC_W   = FP32_W,
    parameter int FMA_LAT = 1,
    parameter int CNT_W   = 32
) (
    input logic         clk,
    input logic         reset,
    pe_bf16_ws_if.slave bus
);
    logic [IN_W-1:0]  shadow_q, shadow_d, active_q, active_d, east_q;
    logic             east_valid_q, bypass, issue, wzero, busy;
    logic [ACC_W-1:0] c_op, fma_r, result_d, south_hold_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FMA_LAT-1:0][ACC_W:0] taps;
    logic [ACC_W:0]   tail;

    pe_bf16_fma u_fma (
        .a_i(bus.i_west),
        .b_i(active_q),
        .c_i(c_op),
        .r_o(fma_r)
    );

    // the result is fixed at issue, so a later weight swap cannot reach ops already in the pipe
    pe_delay_line #(.DEPTH(FMA_LAT), .WIDTH(ACC_W + 1)) u_pipe (
        .clk(clk),
        .reset(reset),
        .en_i(bus.i_en),
        .d_i({issue, result_d}),
        .taps_o(taps),
        .q_o(tail)
    );

    // issue decision, operand selection and next-state for weights and counter
    always_comb begin
        bypass   = pe_mode_e'(bus.i_mode) == PE_MODE_BYPASS;
        issue    = bypass ? bus.i_north_valid : bus.i_west_valid;
        c_op     = bus.i_north_valid ? bus.i_north : FP32_ZERO;
        wzero    = active_q[IN_W-2:0] == '0;
        result_d = bypass ? bus.i_north : (wzero ? c_op : fma_r);
        shadow_d = bus.i_wload ? bus.i_weight : shadow_q;
        active_d = bus.i_wswap ? shadow_q : active_q;
        cnt_d    = (issue && !bypass && !wzero && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        busy     = 1'b0;
        for (int k = 0; k < FMA_LAT; k++) busy = busy | taps[k][ACC_W];
    end

    // architectural state; i_en low freezes everything, reset wins over i_en
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_q     <= '0;
            active_q     <= '0;
            east_q       <= '0;
            east_valid_q <= 1'b0;
            south_hold_q <= '0;
            cnt_q        <= '0;
        end else if (bus.i_en) begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            east_q       <= bus.i_west;
            east_valid_q <= bus.i_west_valid;
            cnt_q        <= cnt_d;
            if (tail[ACC_W]) south_hold_q <= tail[ACC_W-1:0];
        end
    end

    assign bus.o_weight      = shadow_q;
    assign bus.o_east        = east_q;
    assign bus.o_east_valid  = east_valid_q;
    assign bus.o_south_valid = tail[ACC_W];
    assign bus.o_south       = tail[ACC_W] ? tail[ACC_W-1:0] : south_hold_q;
    assign bus.o_busy        = busy;
    assign bus.o_mac_count   = cnt_q;
endmodule

// File: tb/tb_pe_bf16_ws.sv
// tb_pe_bf16_ws: directed checks of three PE variants (latency 2, latency 3, latency 1 with 4-bit counter)
module tb_pe_bf16_ws;
    logic        clk = 1'b0;
    logic        rst_n, en, mode, wload, wswap, wv, nv;
    logic [15:0] weight, west;
    logic [31:0] north;
    int          total = 0;
    int          bad = 0;
    int          stale;

    pe_bf16_ws_if #(.CNT_W(32)) if2 ();
    pe_bf16_ws_if #(.CNT_W(32)) if3 ();
    pe_bf16_ws_if #(.CNT_W(4))  ifc ();

    pe_bf16_ws #(.FMA_LAT(2), .CNT_W(32)) u_d2 (.clk(clk), .reset(rst_n), .bus(if2.slave));
    pe_bf16_ws #(.FMA_LAT(3), .CNT_W(32)) u_d3 (.clk(clk), .reset(rst_n), .bus(if3.slave));
    pe_bf16_ws #(.FMA_LAT(1), .CNT_W(4))  u_dc (.clk(clk), .reset(rst_n), .bus(ifc.slave));

    always #5 clk = ~clk;

    // every variant sees identical stimulus
    always_comb begin
        if2.i_en = en;             if3.i_en = en;             ifc.i_en = en;
        if2.i_mode = mode;         if3.i_mode = mode;         ifc.i_mode = mode;
        if2.i_wload = wload;       if3.i_wload = wload;       ifc.i_wload = wload;
        if2.i_wswap = wswap;       if3.i_wswap = wswap;       ifc.i_wswap = wswap;
        if2.i_weight = weight;     if3.i_weight = weight;     ifc.i_weight = weight;
        if2.i_west = west;         if3.i_west = west;         ifc.i_west = west;
        if2.i_west_valid = wv;     if3.i_west_valid = wv;     ifc.i_west_valid = wv;
        if2.i_north = north;       if3.i_north = north;       ifc.i_north = north;
        if2.i_north_valid = nv;    if3.i_north_valid = nv;    ifc.i_north_valid = nv;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; mode = 1'b0; wload = 1'b0; wswap = 1'b0; weight = '0;
        west = '0; wv = 1'b0; north = '0; nv = 1'b0;
    endtask

    logic [15:0] tw [3] = '{16'h3FC0, 16'hC040, 16'h4040};
    logic [31:0] tn [3] = '{32'hBF80_0000, 32'h4040_0000, 32'h3F80_0000};
    logic [31:0] te [3] = '{32'h3F00_0000, 32'h0000_0000, 32'h4080_0000};

    initial begin
        idle();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_south", if2.o_south, 0);
        check("rst_sv", if2.o_south_valid, 0);
        check("rst_busy", if2.o_busy, 0);
        check("rst_cnt", if2.o_mac_count, 0);
        check("rst_wt", if2.o_weight, 0);
        check("rst_east", if2.o_east, 0);
        check("rst_ev", if2.o_east_valid, 0);

        // basic MAC: 1.0 * 2.0 + 1.0
        wload = 1; weight = 16'h4000; tick();
        wload = 0; wswap = 1; tick();
        wswap = 0;
        check("t1_wt", if2.o_weight, 16'h4000);
        west = 16'h3F80; wv = 1; north = 32'h3F80_0000; nv = 1; tick();
        west = 0; wv = 0; north = 0; nv = 0;
        check("t1_east", if2.o_east, 16'h3F80);
        check("t1_ev", if2.o_east_valid, 1);
        check("t1_sv_early", if2.o_south_valid, 0);
        check("t1_busy", if2.o_busy, 1);
        tick();
        check("t1_sv", if2.o_south_valid, 1);
        check("t1_south", if2.o_south, 32'h4040_0000);
        check("t1_cnt", if2.o_mac_count, 1);
        check("t1_ev_drop", if2.o_east_valid, 0);
        tick();
        check("t1_sv_drop", if2.o_south_valid, 0);
        check("t1_hold", if2.o_south, 32'h4040_0000);

        // simultaneous load and swap: active takes old shadow 1.0
        wload = 1; weight = 16'h3F80; tick();
        wswap = 1; weight = 16'h4000; tick();
        wload = 0; wswap = 0;
        check("t2_wt", if2.o_weight, 16'h4000);
        west = 16'h4000; wv = 1; tick();
        west = 0; wv = 0; tick();
        check("t2_sv", if2.o_south_valid, 1);
        check("t2_south", if2.o_south, 32'h4000_0000);
        check("t2_cnt", if2.o_mac_count, 2);

        // swap to zero weight while an op is in flight (latency 3)
        wswap = 1; tick();
        wswap = 0; west = 16'h3F80; wv = 1; wload = 1; weight = 16'h0000; tick();
        wv = 0; wload = 0; wswap = 1; tick();
        wswap = 0; west = 16'h3F80; wv = 1; north = 32'h40A0_0000; nv = 1; tick();
        west = 0; wv = 0; north = 0; nv = 0;
        check("t3_sv1", if3.o_south_valid, 1);
        check("t3_r1", if3.o_south, 32'h4000_0000);
        tick();
        check("t3_gap", if3.o_south_valid, 0);
        check("t3_hold", if3.o_south, 32'h4000_0000);
        tick();
        check("t3_sv2", if3.o_south_valid, 1);
        check("t3_r2", if3.o_south, 32'h40A0_0000);
        check("t3_cnt", if3.o_mac_count, 3);

        // bypass with a two-cycle stall in flight
        mode = 1; north = 32'h1234_5678; nv = 1; tick();
        mode = 0; north = 0; nv = 0;
        check("t4_busy", if2.o_busy, 1);
        check("t4_sv0", if2.o_south_valid, 0);
        en = 0; west = 16'h4000; wv = 1; tick();
        check("t4_st1", if2.o_south_valid, 0);
        check("t4_ehold", if2.o_east_valid, 0);
        tick();
        check("t4_st2", if2.o_south_valid, 0);
        check("t4_stbusy", if2.o_busy, 1);
        west = 0; wv = 0; en = 1; tick();
        check("t4_sv", if2.o_south_valid, 1);
        check("t4_south", if2.o_south, 32'h1234_5678);
        check("t4_cnt", if2.o_mac_count, 3);

        // reset with three ops in flight
        wload = 1; weight = 16'h3F80; tick();
        wload = 0; wswap = 1; tick();
        wswap = 0; west = 16'h3F80; wv = 1; north = 32'h3F80_0000; nv = 1; tick();
        north = 32'h4000_0000; tick();
        check("t5_b1_sv", if2.o_south_valid, 1);
        check("t5_b1", if2.o_south, 32'h4000_0000);
        north = 32'h4040_0000; tick();
        check("t5_b2", if2.o_south, 32'h4040_0000);
        check("t5_b3", if3.o_south, 32'h4000_0000);
        idle();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        check("t5_sv", if3.o_south_valid, 0);
        check("t5_busy", if3.o_busy, 0);
        check("t5_cnt", if3.o_mac_count, 0);
        check("t5_east", if3.o_east, 0);
        check("t5_ev", if3.o_east_valid, 0);
        check("t5_south", if3.o_south, 0);
        stale = 0;
        repeat (4) begin
            tick();
            stale += int'(if2.o_south_valid) + int'(if3.o_south_valid) + int'(ifc.o_south_valid);
        end
        check("t5_stale", stale, 0);

        // latency-1 arithmetic vectors, then counter saturation
        wload = 1; weight = 16'h3F80; tick();
        wload = 0; wswap = 1; tick();
        wswap = 0;
        for (int i = 0; i < 3; i++) begin
            west = tw[i]; wv = 1; north = tn[i]; nv = 1; tick();
            check("tc_sv", ifc.o_south_valid, 1);
            check("tc_vec", ifc.o_south, te[i]);
        end
        nv = 0; north = 0;
        check("tc_cnt3", ifc.o_mac_count, 3);
        west = 16'h3F80; wv = 1;
        repeat (12) tick();
        check("tc_cnt15", ifc.o_mac_count, 4'hF);
        repeat (5) tick();
        wv = 0; tick();
        check("tc_sat", ifc.o_mac_count, 4'hF);
        check("tc_wide", if2.o_mac_count, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pe_bf16_ws.md
Name: pe_bf16_ws

Overview:
- Parametrised weight-stationary systolic processing element; successor to the single-cycle bf16 PE.
- Computes o_south = i_west * weight + i_north using the existing FMA unit: bf16 x bf16 + fp32 -> fp32.
- Adds the following over the single-cycle PE:
  - double-buffered weights with a shift-chain load;
  - valid tracking;
  - configurable FMA pipeline depth;
  - clock-enable stall;
  - bypass mode;
  - zero-weight skip;
  - a MAC performance counter.
- Tiles into an R x C array; a column of PEs shares i_wload/i_wswap.

Parameters:
- IN_W, 16: activation/weight width (bf16).
- ACC_W, 32: partial-sum width (fp32).
- FMA_LAT, 1: cycles from issue to o_south; legal range 1..4.
- CNT_W, 32: MAC counter width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset; asserted when reset==0 at a rising clk edge.
- i_en  in  1  global enable; 0 freezes all state.
- i_mode  in  1  0=FMA, 1=bypass (north passed south unchanged).
- i_wload  in  1  shift i_weight into the shadow weight register.
- i_wswap  in  1  copy shadow weight to active weight.
- i_weight  in  IN_W  weight shift-chain input from the north neighbour.
- o_weight  out  IN_W  shadow weight register, feeding the south neighbour's i_weight.
- i_west  in  IN_W  activation.
- i_west_valid  in  1  activation valid.
- o_east  out  IN_W  registered activation.
- o_east_valid  out  1  registered activation valid.
- i_north  in  ACC_W  partial sum in.
- i_north_valid  in  1  partial sum valid.
- o_south  out  ACC_W  partial sum out.
- o_south_valid  out  1  partial sum valid.
- o_busy  out  1  at least one op in flight.
- o_mac_count  out  CNT_W  count of real MACs issued.

Behaviour:
- Reset (reset==0 at a clk edge). All of the following become 0:
  - weight state: shadow weight, active weight, o_weight;
  - east path: o_east, o_east_valid;
  - south path: o_south, o_south_valid;
  - pipeline: all in-flight valids;
  - status: o_mac_count, o_busy.
  - In-flight ops are discarded, including on a mid-operation reset.
  - Reset has priority over i_en.
- Stall: i_en==0 holds every register, including the counter; inputs are ignored that cycle.
- Weights (when i_en==1):
  - i_wload: shadow <= i_weight.
  - i_wswap: active <= shadow (the old shadow value).
  - Both in the same cycle: active takes the old shadow, shadow takes i_weight.
  - Loading an N-row column takes N cycles of i_wload, then one i_wswap.
  - In-flight ops keep the weight captured at issue; a swap never corrupts them.
- East path: o_east <= i_west and o_east_valid <= i_west_valid, 1-cycle latency, independent of mode.
  - External skew logic absorbs the FMA_LAT-1 mismatch.
- Issue condition:
  - FMA mode: i_west_valid==1; the c operand is i_north if i_north_valid, else +0.0 (0x00000000).
  - Bypass mode: i_north_valid==1.
  - i_mode is sampled at issue and travels with the op.
- Zero-weight skip: if the active weight's magnitude bits [IN_W-2:0]==0, result = c operand exactly; the FMA output is ignored.
- Pipeline:
  - Result and valid travel an FMA_LAT-deep register chain.
  - o_south_valid is asserted exactly FMA_LAT enabled cycles after issue.
  - Back-to-back issue every cycle is supported; no bubbles.
  - Bypass mode uses the same depth, so latency is mode-invariant.
  - o_south holds its last value when o_south_valid==0.
- o_busy: OR of all in-flight valid bits.
- Counter: +1 per FMA-mode issue with a non-zero active weight.
  - Saturates at all-ones; never wraps.

Decomposition:
- Shared package pe_pkg contains:
  - BF16_W=16, FP32_W=32;
  - FP32_ZERO=32'h0;
  - mode enum PE_MODE_FMA=0, PE_MODE_BYPASS=1.
- One sub-module, pe_delay_line: a parametrised (DEPTH, WIDTH) enable-gated shift register with sync active-low clear.
  - Instantiated once for {valid, result}.
- The FMA unit is reused unchanged.

Test Plan:
- Basic MAC, FMA_LAT=2:
  - Stimulus: load weight 0x4000 (2.0), swap; then i_west=0x3F80 (1.0) and i_north=0x3F800000 (1.0), both valid.
  - Response: o_south=0x40400000 (3.0) with o_south_valid exactly 2 cycles later; o_east=0x3F80 after 1 cycle; o_mac_count=1.
- Shift chain plus simultaneous load/swap:
  - Stimulus: shadow=0x3F80; apply i_wload=1, i_wswap=1 with i_weight=0x4000.
  - Response: active=0x3F80, o_weight=0x4000.
  - Follow-up: a MAC issued next cycle with west 2.0 (0x4000) and north 0 gives 0x40000000.
- Swap mid-flight, FMA_LAT=3:
  - Stimulus: issue with weight 2.0, swap to 0x0000 the next cycle.
  - Response: first result uses 2.0; a second issue with north 0x40A00000 returns 0x40A00000 via zero-skip; counter increments only once.
- Bypass plus stall:
  - Stimulus: mode=1, i_north=0x12345678 valid; hold i_en=0 for 2 cycles mid-flight.
  - Response: output appears FMA_LAT+2 cycles after issue with an unchanged value; counter unchanged.
- Reset mid-operation:
  - Stimulus: 3 ops in flight, drive reset=0 for one edge.
  - Response: o_south_valid, o_busy, o_mac_count, o_east all 0 the next cycle; no stale output afterward.
- Counter saturation:
  - Stimulus: CNT_W=4, issue 20 nonzero-weight MACs.
  - Response: o_mac_count stops at 4'hF.
